// File: rtl/text_grid_pkg.sv
// Shared types and defaults for the character-grid writer.
// Holds the writer FSM state encoding and the default clear character.
// Also provides a saturating 8-bit increment used by the drop counter.
package text_grid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/text_grid_fifo.sv
// Write-request queue: show-ahead FIFO, head entry visible while not empty.
// Latency: an entry pushed on one edge is at the head after that edge.
// Backpressure: o_full blocks pushes; pop of an empty queue is ignored.
module text_grid_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             FPGA_clock,
    input  logic             iRST_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_ff @(posedge FPGA_clock or negedge iRST_n) begin
        if (!iRST_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop && !o_empty)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge FPGA_clock) begin
        if (i_push && !o_full)
            r_mem[r_wr_ptr[PW-1:0]] <= i_push_dat;
    end

    assign o_pop_dat = r_mem[r_rd_ptr[PW-1:0]];
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

endmodule

// File: rtl/text_grid_writer.sv
// Character-grid memory: queued cell writes, full-screen clear, registered read port.
// Latency: idle write lands on the 2nd edge after acceptance; rd_char is 1 cycle after rd_x/rd_y.
// Backpressure: wr_ready = queue not full, also during a clear. Option: TEXT_GRID_DEDUP_EN.
module text_grid_writer
    import text_grid_pkg::*;
#(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 60,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] FILL_CHAR  = FILL_CHAR_DEFAULT
) (
    input  logic                    FPGA_clock,
    input  logic                    iRST_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [7:0]              wr_char,
    input  logic [$clog2(COLS)-1:0] wr_x,
    input  logic [$clog2(ROWS)-1:0] wr_y,
    input  logic                    clr_req,
    input  logic [$clog2(COLS)-1:0] rd_x,
    input  logic [$clog2(ROWS)-1:0] rd_y,
    output logic [7:0]              rd_char,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);
    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int EW    = 8 + XW + YW;
    localparam logic [XW:0]   COLS_LIM  = (XW+1)'(COLS);
    localparam logic [YW:0]   ROWS_LIM  = (YW+1)'(ROWS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_addr;
    logic [7:0]      r_mem [CELLS];
    logic [7:0]      r_rd_char;
    logic [7:0]      r_drop_cnt;

    logic            w_accept;
    logic            w_push;
    logic [EW-1:0]   w_entry;
    logic [EW-1:0]   w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [7:0]      w_head_char;
    logic [XW-1:0]   w_head_x;
    logic [YW-1:0]   w_head_y;
    logic            w_head_ok;
    logic [AW-1:0]   w_head_addr;
    logic            w_rd_ok;
    logic [AW-1:0]   w_rd_addr;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [7:0]      w_mem_dat;
    logic            w_drop;

    assign wr_ready = iRST_n & ~w_full;
    assign busy     = ~iRST_n | (r_state == CLEAR) | ~w_empty;
    assign w_accept = wr_valid & wr_ready;
    assign w_entry  = {wr_char, wr_x, wr_y};

`ifdef TEXT_GRID_DEDUP_EN
    logic          r_last_vld;
    logic [EW-1:0] r_last_dat;

    // Remember the latest accepted write so an exact repeat can be skipped.
    always_ff @(posedge FPGA_clock or negedge iRST_n) begin
        if (!iRST_n) begin
            r_last_vld <= 1'b0;
            r_last_dat <= '0;
        end else if (w_accept) begin
            r_last_vld <= 1'b1;
            r_last_dat <= w_entry;
        end
    end

    assign w_push = w_accept && !(r_last_vld && (r_last_dat == w_entry));
`else
    assign w_push = w_accept;
`endif

    text_grid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .FPGA_clock (FPGA_clock),
        .iRST_n     (iRST_n),
        .i_push     (w_push),
        .i_push_dat (w_entry),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_head_char = w_head[EW-1 -: 8];
    assign w_head_x    = w_head[XW+YW-1 -: XW];
    assign w_head_y    = w_head[YW-1:0];
    assign w_head_ok   = ({1'b0, w_head_x} < COLS_LIM) && ({1'b0, w_head_y} < ROWS_LIM);
    assign w_head_addr = AW'(w_head_y) * AW'(COLS) + AW'(w_head_x);
    assign w_rd_ok     = ({1'b0, rd_x} < COLS_LIM) && ({1'b0, rd_y} < ROWS_LIM);
    assign w_rd_addr   = AW'(rd_y) * AW'(COLS) + AW'(rd_x);

    // State register; reset parks in CLEAR so the sweep starts on release.
    always_ff @(posedge FPGA_clock or negedge iRST_n) begin
        if (!iRST_n)
            r_state <= CLEAR;
        else
            r_state <= w_state_nxt;
    end

    // Next state and the single memory write port selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_clr_addr;
        w_mem_dat   = FILL_CHAR;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_req)
                    w_state_nxt = CLEAR;
                else if (!w_empty)
                    w_state_nxt = WRITE;
            end
            WRITE: begin
                w_pop = 1'b1;
                if (w_head_ok) begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = w_head_addr;
                    w_mem_dat  = w_head_char;
                end else begin
                    w_drop = 1'b1;
                end
                w_state_nxt = clr_req ? CLEAR : IDLE;
            end
            CLEAR: begin
                w_mem_we = 1'b1;
                if (!clr_req && (r_clr_addr == LAST_ADDR))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sweep address: held at 0 outside CLEAR, and a new request restarts it.
    always_ff @(posedge FPGA_clock or negedge iRST_n) begin
        if (!iRST_n)
            r_clr_addr <= '0;
        else if ((r_state != CLEAR) || clr_req)
            r_clr_addr <= '0;
        else
            r_clr_addr <= r_clr_addr + AW'(1);
    end

    // Cell storage write port; contents are defined by the clear sweep.
    always_ff @(posedge FPGA_clock) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_dat;
    end

    // Display read port, never stalled by writes; off-grid lookups return 0.
    always_ff @(posedge FPGA_clock or negedge iRST_n) begin
        if (!iRST_n)
            r_rd_char <= 8'h00;
        else
            r_rd_char <= w_rd_ok ? r_mem[w_rd_addr] : 8'h00;
    end

    // Count off-grid writes as they are popped, saturating at 255.
    always_ff @(posedge FPGA_clock or negedge iRST_n) begin
        if (!iRST_n)
            r_drop_cnt <= 8'h00;
        else if (w_drop)
            r_drop_cnt <= sat_inc8(r_drop_cnt);
    end

    assign rd_char  = r_rd_char;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_text_grid_writer.sv
// Bench for text_grid_writer: directed scenarios plus random traffic against a
// transaction-level grid model that is checked whenever the writer is idle.
// Optional dedup behaviour follows TEXT_GRID_DEDUP_EN.
module tb_text_grid_writer;
    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int DEPTH = 8;
    localparam int CELLS = COLS * ROWS;

    logic       FPGA_clock = 1'b0;
    logic       iRST_n     = 1'b0;
    logic       wr_valid   = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_char    = 8'h00;
    logic [6:0] wr_x       = 7'd0;
    logic [5:0] wr_y       = 6'd0;
    logic       clr_req    = 1'b0;
    logic [6:0] rd_x       = 7'd0;
    logic [5:0] rd_y       = 6'd0;
    logic [7:0] rd_char;
    logic       busy;
    logic [7:0] drop_cnt;

    text_grid_writer #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .FIFO_DEPTH (DEPTH),
        .FILL_CHAR  (8'h20)
    ) dut (
        .FPGA_clock (FPGA_clock),
        .iRST_n     (iRST_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_char    (wr_char),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .clr_req    (clr_req),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_char    (rd_char),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 FPGA_clock = ~FPGA_clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] c;
        int         x;
        int         y;
    } wr_t;

    logic [7:0] m_mem [CELLS];
    int         m_drop;
    wr_t        m_pend [$];
    logic       m_last_vld;
    wr_t        m_last;

    function automatic void m_clear();
        for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h20;
    endfunction

    function automatic void m_reset();
        m_clear();
        m_pend.delete();
        m_drop     = 0;
        m_last_vld = 1'b0;
    endfunction

    function automatic void m_accept(input logic [7:0] c, input int x, input int y);
        wr_t e;
        e.c = c; e.x = x; e.y = y;
`ifdef TEXT_GRID_DEDUP_EN
        if (m_last_vld && m_last.c == c && m_last.x == x && m_last.y == y)
            return;
`endif
        m_pend.push_back(e);
        m_last     = e;
        m_last_vld = 1'b1;
    endfunction

    function automatic void m_flush();
        wr_t e;
        while (m_pend.size() > 0) begin
            e = m_pend.pop_front();
            if (e.x >= COLS || e.y >= ROWS) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_mem[e.y * COLS + e.x] = e.c;
            end
        end
    endfunction

    // ---------------- compare process ----------------
    logic prev_idle = 1'b0;
    int   px = 0;
    int   py = 0;

    initial begin
        forever begin
            @(negedge FPGA_clock);
            if (iRST_n && prev_idle) begin
                check("rd_char", int'(rd_char), int'(m_mem[py * COLS + px]));
                check("drop_cnt", int'(drop_cnt), m_drop);
            end
            if (iRST_n && !busy) m_flush();
            prev_idle = iRST_n && !busy;
            px = int'(rd_x);
            py = int'(rd_y);
        end
    end

    // ---------------- random read-address driver ----------------
    logic rd_rand = 1'b0;

    initial begin
        forever begin
            @(posedge FPGA_clock);
            #1;
            if (rd_rand) begin
                rd_x = 7'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 11) : $urandom_range(72, 79));
                rd_y = 6'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(56, 59));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_write(input logic [7:0] c, input int x, input int y);
        int w;
        w = 0;
        wr_valid = 1'b1; wr_char = c; wr_x = 7'(x); wr_y = 6'(y);
        @(negedge FPGA_clock);
        while (!wr_ready) begin
            w++;
            if (w > 20000) begin
                timeout_fail("wr_accept");
                wr_valid = 1'b0;
                return;
            end
            @(negedge FPGA_clock);
        end
        @(posedge FPGA_clock);
        m_accept(c, x, y);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr_req = 1'b1;
        @(posedge FPGA_clock);
        m_clear();
        #1;
        clr_req = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        forever begin
            @(negedge FPGA_clock);
            if (!busy) break;
            n++;
            if (n > 20000) begin
                timeout_fail("busy_count");
                break;
            end
        end
        @(posedge FPGA_clock);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        count_busy(n);
    endtask

    task automatic read_cell(input int x, input int y, output logic [7:0] v);
        rd_x = 7'(x); rd_y = 6'(y);
        @(posedge FPGA_clock);
        @(negedge FPGA_clock);
        v = rd_char;
        @(posedge FPGA_clock);
        #1;
    endtask

    task automatic sweep_all();
        rd_rand = 1'b0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                rd_x = 7'(x); rd_y = 6'(y);
                @(posedge FPGA_clock);
                #1;
            end
        @(posedge FPGA_clock);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         n;
        int         n_clr;
        logic [7:0] v;
        logic [7:0] lc;
        int         lx, ly;
        logic       have_last;

        m_reset();
        repeat (3) @(posedge FPGA_clock);
        #1;
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_rd_char", int'(rd_char), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);

        // Reset release starts a full clear sweep.
        iRST_n = 1'b1;
        count_busy(n);
        check("init_clear_cycles", n, 4800);
        sweep_all();
        read_cell(79, 59, v);
        check("fill_corner", int'(v), 8'h20);

        // Single idle write: visible after the 2nd edge plus one read cycle.
        rd_x = 7'd5; rd_y = 6'd3;
        do_write(8'h41, 5, 3);
        @(posedge FPGA_clock);
        @(negedge FPGA_clock);
        check("wr_latency_before", int'(rd_char), 8'h20);
        @(posedge FPGA_clock);
        @(posedge FPGA_clock);
        @(negedge FPGA_clock);
        check("wr_latency_after", int'(rd_char), 8'h41);
        @(posedge FPGA_clock);
        #1;

        // Off-grid writes are dropped and counted.
        do_write(8'h58, 80, 0);
        wait_idle();
        check("drop_one", int'(drop_cnt), 1);
        read_cell(0, 1, v);
        check("drop_no_write", int'(v), 8'h20);
        do_write(8'h51, 81, 0);
        do_write(8'h51, 81, 0);
        wait_idle();
`ifdef TEXT_GRID_DEDUP_EN
        check("dedup_repeat", int'(drop_cnt), 2);
`else
        check("repeat_queued", int'(drop_cnt), 3);
`endif
        for (int i = 0; i < 297; i++) do_write(8'(i), 80 + (i % 8), 0);
        wait_idle();
        check("drop_saturate", int'(drop_cnt), 255);

        // Fill the queue while a clear blocks pops; ninth write waits.
        do_clr();
        for (int i = 0; i < 8; i++) do_write(8'h61 + 8'(i), i, 10);
        @(negedge FPGA_clock);
        check("full_after_8", int'(wr_ready), 0);
        @(posedge FPGA_clock);
        #1;
        do_write(8'h5A, 0, 10);
        wait_idle();
        read_cell(0, 10, v);
        check("order_last_wins", int'(v), 8'h5A);
        read_cell(7, 10, v);
        check("queued_8th", int'(v), 8'h68);
        read_cell(5, 3, v);
        check("cleared_A", int'(v), 8'h20);

        // Clear restart at sweep address 2000 with a write queued meanwhile.
        do_clr();
        do_write(8'h4B, 40, 30);
        repeat (1999) @(posedge FPGA_clock);
        #1;
        clr_req = 1'b1;
        @(posedge FPGA_clock);
        m_clear();
        #1;
        clr_req = 1'b0;
        count_busy(n);
        check("restart_cycles", n, 4802);
        read_cell(40, 30, v);
        check("write_after_clear", int'(v), 8'h4B);

        // Random traffic.
        rd_rand   = 1'b1;
        have_last = 1'b0;
        n_clr     = 0;
        lc = 8'h00; lx = 0; ly = 0;
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 65) begin
                if (!(r < 12 && have_last)) begin
                    lc = 8'($urandom_range(0, 255));
                    lx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 11)) : int'($urandom_range(72, 83));
                    ly = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(56, 63));
                end
                have_last = 1'b1;
                do_write(lc, lx, ly);
            end else if (r < 92) begin
                repeat ($urandom_range(1, 6)) @(posedge FPGA_clock);
                #1;
            end else if (r == 99 && n_clr < 3) begin
                n_clr++;
                wait_idle();
                do_clr();
            end else begin
                wait_idle();
            end
        end
        wait_idle();

        // Reset in the middle of a clear with queued writes.
        do_clr();
        rd_rand = 1'b0;
        do_write(8'h52, 2, 2);
        do_write(8'h53, 3, 2);
        iRST_n = 1'b0;
        m_reset();
        @(negedge FPGA_clock);
        check("midrst_wr_ready", int'(wr_ready), 0);
        check("midrst_busy", int'(busy), 1);
        check("midrst_rd_char", int'(rd_char), 0);
        check("midrst_drop_cnt", int'(drop_cnt), 0);
        @(posedge FPGA_clock);
        #1;
        iRST_n = 1'b1;
        count_busy(n);
        check("midrst_clear_cycles", n, 4800);
        read_cell(2, 2, v);
        check("midrst_queue_lost", int'(v), 8'h20);
        do_write(8'h52, 2, 2);
        wait_idle();
        read_cell(2, 2, v);
        check("first_after_reset", int'(v), 8'h52);

        sweep_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
